// File: rtl/register_file.sv
// register_file: 32 x 32-bit general-purpose register file for the RISCVPy
// writeback stage. Two combinational read ports, one synchronous write port.
// Entry 0 is an ordinary register. Asynchronous active-low reset clears all.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LD,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] D_IN,
    output logic [DATA_W-1:0] DATA_A,
    output logic [DATA_W-1:0] DATA_B
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Next-state: hold every entry; only when LD is high is entry DR replaced.
    // DR and D_IN are never looked at while LD is low, so X there is harmless.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (LD == 1'b1) begin
            regs_d[DR] = D_IN;
        end
    end

    // Storage: reset clears every entry immediately and overrides any write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: zero-latency, no write bypass; new data shows after the edge.
    always_comb begin
        DATA_A = regs_q[SA];
        DATA_B = regs_q[SB];
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file.
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              CLK;
    logic              RST_N;
    logic              LD;
    logic [ADDR_W-1:0] SA;
    logic [ADDR_W-1:0] SB;
    logic [ADDR_W-1:0] DR;
    logic [DATA_W-1:0] D_IN;
    logic [DATA_W-1:0] DATA_A;
    logic [DATA_W-1:0] DATA_B;

    int total;
    int bad;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .LD    (LD),
        .SA    (SA),
        .SB    (SB),
        .DR    (DR),
        .D_IN  (D_IN),
        .DATA_A(DATA_A),
        .DATA_B(DATA_B)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        LD = 1'b0; DR = '0; D_IN = '0; SA = 5'd0; SB = 5'd31;
        RST_N = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (DATA_A !== 32'h0) begin
            bad++; $display("FAIL reset_during_a got=%h exp=%h", DATA_A, 32'h0);
        end
        total++;
        if (DATA_B !== 32'h0) begin
            bad++; $display("FAIL reset_during_b got=%h exp=%h", DATA_B, 32'h0);
        end
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            SA = 5'(i);
            SB = 5'(31 - i);
            #1;
            total++;
            if (DATA_A !== 32'h0) begin
                bad++; $display("FAIL reset_sweep_a[%0d] got=%h exp=%h", i, DATA_A, 32'h0);
            end
            total++;
            if (DATA_B !== 32'h0) begin
                bad++; $display("FAIL reset_sweep_b[%0d] got=%h exp=%h", 31 - i, DATA_B, 32'h0);
            end
        end
    endtask

    task automatic test_write_x0_x1();
        LD = 1'b1; DR = 5'd0; D_IN = 32'h0000_0123;
        tick();
        DR = 5'd1; D_IN = 32'h0000_0321;
        tick();
        LD = 1'b0; D_IN = 'x; DR = 'x; SA = 5'd0; SB = 5'd1;
        #1;
        total++;
        if (DATA_A !== 32'h0000_0123) begin
            bad++; $display("FAIL write_x0 got=%h exp=%h", DATA_A, 32'h0000_0123);
        end
        total++;
        if (DATA_B !== 32'h0000_0321) begin
            bad++; $display("FAIL write_x1 got=%h exp=%h", DATA_B, 32'h0000_0321);
        end
        tick();
        total++;
        if (DATA_A !== 32'h0000_0123 || DATA_B !== 32'h0000_0321) begin
            bad++; $display("FAIL x_data_hold got=%h/%h exp=%h/%h", DATA_A, DATA_B,
                            32'h0000_0123, 32'h0000_0321);
        end
    endtask

    task automatic test_write_disable();
        LD = 1'b0; DR = 5'd1; D_IN = 32'hDEAD_BEEF; SB = 5'd1; SA = 5'd0;
        tick();
        total++;
        if (DATA_B !== 32'h0000_0321) begin
            bad++; $display("FAIL ld0_x1 got=%h exp=%h", DATA_B, 32'h0000_0321);
        end
        total++;
        if (DATA_A !== 32'h0000_0123) begin
            bad++; $display("FAIL ld0_x0 got=%h exp=%h", DATA_A, 32'h0000_0123);
        end
        for (int i = 2; i < 32; i++) begin
            SA = 5'(i);
            #1;
            total++;
            if (DATA_A !== 32'h0) begin
                bad++; $display("FAIL ld0_other[%0d] got=%h exp=%h", i, DATA_A, 32'h0);
            end
        end
    endtask

    task automatic test_collision();
        SA = 5'd5; SB = 5'd5; LD = 1'b1; DR = 5'd5; D_IN = 32'hA5A5_A5A5;
        #1;
        total++;
        if (DATA_A !== 32'h0) begin
            bad++; $display("FAIL collide_before got=%h exp=%h", DATA_A, 32'h0);
        end
        tick();
        LD = 1'b0;
        total++;
        if (DATA_A !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL collide_after_a got=%h exp=%h", DATA_A, 32'hA5A5_A5A5);
        end
        total++;
        if (DATA_B !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL collide_after_b got=%h exp=%h", DATA_B, 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) begin
            LD = 1'b1; DR = 5'(i); D_IN = 32'(i) * 32'h0101_0101;
            tick();
        end
        LD = 1'b0;
        for (int i = 0; i < 32; i++) begin
            SA = 5'(i);
            SB = 5'(31 - i);
            #1;
            total++;
            if (DATA_A !== 32'(i) * 32'h0101_0101) begin
                bad++; $display("FAIL sweep_a[%0d] got=%h exp=%h", i, DATA_A,
                                32'(i) * 32'h0101_0101);
            end
            total++;
            if (DATA_B !== 32'(31 - i) * 32'h0101_0101) begin
                bad++; $display("FAIL sweep_b[%0d] got=%h exp=%h", 31 - i, DATA_B,
                                32'(31 - i) * 32'h0101_0101);
            end
        end
    endtask

    task automatic test_async_reset();
        SA = 5'd7; SB = 5'd31;
        tick();
        total++;
        if (DATA_A !== 32'h0707_0707 || DATA_B !== 32'h1F1F_1F1F) begin
            bad++; $display("FAIL pre_reset got=%h/%h exp=%h/%h", DATA_A, DATA_B,
                            32'h0707_0707, 32'h1F1F_1F1F);
        end
        LD = 1'b1; DR = 5'd3; D_IN = 32'hFFFF_FFFF;
        #1;
        RST_N = 1'b0;
        #1;
        total++;
        if (DATA_A !== 32'h0) begin
            bad++; $display("FAIL async_clear_a got=%h exp=%h", DATA_A, 32'h0);
        end
        total++;
        if (DATA_B !== 32'h0) begin
            bad++; $display("FAIL async_clear_b got=%h exp=%h", DATA_B, 32'h0);
        end
        tick();
        tick();
        SA = 5'd3;
        #1;
        RST_N = 1'b1;
        LD = 1'b0;
        #1;
        total++;
        if (DATA_A !== 32'h0) begin
            bad++; $display("FAIL no_write_in_reset got=%h exp=%h", DATA_A, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            SB = 5'(i);
            #1;
            total++;
            if (DATA_B !== 32'h0) begin
                bad++; $display("FAIL post_reset_sweep[%0d] got=%h exp=%h", i, DATA_B, 32'h0);
            end
        end
        LD = 1'b1; DR = 5'd3; D_IN = 32'h0000_0077;
        tick();
        LD = 1'b0;
        total++;
        if (DATA_A !== 32'h0000_0077) begin
            bad++; $display("FAIL write_after_reset got=%h exp=%h", DATA_A, 32'h0000_0077);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_write_x0_x1();
        test_write_disable();
        test_collision();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
